// File: rtl/fxyz_pkg.sv
// fxyz_pkg: shared definitions for the fxyz truth-table sweep stage.
//   - sweep_state_e : sweep FSM states
//   - FXYZ_N        : default number of function inputs
//   - FXYZ_SETTLE   : default settle cycles per row
//   - FXYZ_ROWS     : 2^FXYZ_N truth-table rows
//   - FXYZ_GOLDEN   : known-good minterm mask of the fxyz function
package fxyz_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } sweep_state_e;

    localparam int unsigned FXYZ_N      = 3;
    localparam int unsigned FXYZ_SETTLE = 2;
    localparam int unsigned FXYZ_ROWS   = 1 << FXYZ_N;

    localparam logic [FXYZ_ROWS-1:0] FXYZ_GOLDEN = 8'h54;

endpackage

// File: rtl/fxyz_first_diff.sv
// fxyz_first_diff: combinational priority encoder returning the lowest set
// bit index of a difference vector (0 when no bit is set).
//   i_diff [2^N-1:0] : captured table XOR expected mask
//   o_idx  [N-1:0]   : lowest index with i_diff set
module fxyz_first_diff
    import fxyz_pkg::*;
#(
    parameter int unsigned N = FXYZ_N
) (
    input  logic [(1<<N)-1:0] i_diff,
    output logic [N-1:0]      o_idx
);

    localparam int ROWS = 1 << N;

    // Scan downwards so the lowest set bit is the last assignment to win.
    always_comb begin
        o_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (i_diff[i]) begin
                o_idx = N'(i);
            end
        end
    end

endmodule

// File: rtl/fxyz_sweep.sv
// fxyz_sweep: drives every input row of a fxyz function block in ascending
// order, holds each row SETTLE+1 cycles, samples the function output once per
// row and assembles the captured minterm mask.
//
// Optional feature macro: FXYZ_SWEEP_CHECK_EN
//   defined   : compares the final mask with i_expected, reports match and the
//               lowest failing row.
//   undefined : no compare logic, o_match / o_mismatch_row tied to 0.
//
// Ports:
//   i_clk          : clock, rising edge
//   i_reset        : asynchronous active-high reset
//   i_start        : begin a sweep (honoured only in idle)
//   i_s_in         : function output from the fxyz instance
//   i_expected     : golden mask, stable on the edge entering done
//   o_xyz          : row index driven to the function inputs (x = MSB)
//   o_busy         : high while sweeping
//   o_done         : one-cycle pulse at sweep end
//   o_table        : captured mask, bit i = i_s_in at row i
//   o_match        : captured mask equals i_expected
//   o_mismatch_row : lowest differing row, 0 when matching
module fxyz_sweep
    import fxyz_pkg::*;
#(
    parameter int unsigned N      = FXYZ_N,
    parameter int unsigned SETTLE = FXYZ_SETTLE
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_s_in,
    input  logic [(1<<N)-1:0]   i_expected,
    output logic [N-1:0]        o_xyz,
    output logic                o_busy,
    output logic                o_done,
    output logic [(1<<N)-1:0]   o_table,
    output logic                o_match,
    output logic [N-1:0]        o_mismatch_row
);

    localparam int unsigned ROWS = 1 << N;
    localparam int unsigned CW   = $clog2(SETTLE + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N-1:0]  LAST_ROW = N'(ROWS - 1);

    sweep_state_e    r_state;
    logic [N-1:0]    r_row;     // also drives o_xyz: the row and xyz are always equal
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [ROWS-1:0] r_table;

    wire w_last_sample = (r_state == StSample) && (r_row == LAST_ROW);
    wire w_accept      = (r_state == StIdle) && i_start;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_row   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_table <= '0;
                        r_row   <= '0;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= StSettle;
                    end
                end
                StSettle: begin
                    if (r_cnt == '0) begin
                        r_state <= StSample;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                StSample: begin
                    r_table[r_row] <= i_s_in;
                    if (r_row == LAST_ROW) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_row   <= r_row + N'(1);
                        r_cnt   <= CNT_LOAD;
                        r_state <= StSettle;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_xyz   = r_row;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_table = r_table;

`ifdef FXYZ_SWEEP_CHECK_EN
    logic [ROWS-1:0] w_table_final;
    logic [ROWS-1:0] w_diff;
    logic [N-1:0]    w_first;
    logic            r_match;
    logic [N-1:0]    r_mismatch_row;

    // The last row is still in flight on the edge entering done, so merge it
    // in before comparing.
    always_comb begin
        w_table_final        = r_table;
        w_table_final[r_row] = i_s_in;
    end

    assign w_diff = w_table_final ^ i_expected;

    fxyz_first_diff #(
        .N (N)
    ) u_first_diff (
        .i_diff (w_diff),
        .o_idx  (w_first)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_match        <= 1'b0;
            r_mismatch_row <= '0;
        end else if (w_accept) begin
            r_match        <= 1'b0;
            r_mismatch_row <= '0;
        end else if (w_last_sample) begin
            r_match        <= (w_diff == '0);
            r_mismatch_row <= w_first;
        end
    end

    assign o_match        = r_match;
    assign o_mismatch_row = r_mismatch_row;
`else
    logic w_unused_check;
    assign w_unused_check = ^{i_expected, w_accept, w_last_sample};

    assign o_match        = 1'b0;
    assign o_mismatch_row = '0;
`endif

endmodule

// File: tb/tb_fxyz_sweep.sv
// tb_fxyz_sweep: table-driven bench for fxyz_sweep. A behavioural fxyz model
// (s_in = fmask[xyz]) stands in for the function block.
module tb_fxyz_sweep;

    logic       clk;
    logic       reset;
    logic       start;
    logic       s_in;
    logic [7:0] expected;
    logic [2:0] xyz;
    logic       busy;
    logic       done;
    logic [7:0] tbl;
    logic       match;
    logic [2:0] mismatch_row;

    logic [7:0] fmask;

    int n_checks = 0;
    int n_errors = 0;

    fxyz_sweep u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_s_in         (s_in),
        .i_expected     (expected),
        .o_xyz          (xyz),
        .o_busy         (busy),
        .o_done         (done),
        .o_table        (tbl),
        .o_match        (match),
        .o_mismatch_row (mismatch_row)
    );

    assign s_in = fmask[xyz];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] fm;
        logic [7:0] ex;
        bit         mid_start;
        logic [7:0] exp_table;
        logic       exp_match;
        logic [2:0] exp_row;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // With the compare feature compiled out both flags stay 0.
    function automatic logic cfg_match(input logic m);
`ifdef FXYZ_SWEEP_CHECK_EN
        return m;
`else
        return 1'b0 & m;
`endif
    endfunction

    function automatic logic [2:0] cfg_row(input logic [2:0] r);
`ifdef FXYZ_SWEEP_CHECK_EN
        return r;
`else
        return 3'd0 & r;
`endif
    endfunction

    // One sweep from idle; edge k is the k-th rising edge after start is
    // driven, observed on the following falling edge.
    task automatic sweep(input logic [7:0] fm, input logic [7:0] ex, input bit mid_start,
                         output int done_edge, output int track_err);
        logic [2:0] exp_x;
        logic       exp_b;
        fmask     = fm;
        expected  = ex;
        done_edge = 0;
        track_err = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (mid_start && k == 7) start = 1'b1;
            if (mid_start && k == 8) start = 1'b0;
            exp_x = (k >= 25) ? 3'd7 : 3'(( k - 1) / 3);
            exp_b = (k < 25);
            if (xyz !== exp_x || busy !== exp_b) track_err++;
            if (done === 1'b1) begin
                if (done_edge == 0) done_edge = k;
                else track_err++;
            end
        end
    endtask

    initial begin
        int de;
        int te;
        int first_done;
        int second_done;
        int bad;

        vecs[0] = '{8'h54, 8'h54, 1'b0, 8'h54, 1'b1, 3'd0};
        vecs[1] = '{8'h54, 8'h56, 1'b1, 8'h54, 1'b0, 3'd1};
        vecs[2] = '{8'h54, 8'hFF, 1'b0, 8'h54, 1'b0, 3'd0};
        vecs[3] = '{8'hA5, 8'hA5, 1'b1, 8'hA5, 1'b1, 3'd0};
        vecs[4] = '{8'h00, 8'h80, 1'b0, 8'h00, 1'b0, 3'd7};
        vecs[5] = '{8'h3C, 8'h34, 1'b0, 8'h3C, 1'b0, 3'd3};
        vecs[6] = '{8'hFF, 8'h7F, 1'b0, 8'hFF, 1'b0, 3'd7};

        reset    = 1'b1;
        start    = 1'b0;
        fmask    = 8'h54;
        expected = 8'h54;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({xyz, busy, done, tbl, match, mismatch_row}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", 32'({xyz, busy, done, tbl, match, mismatch_row}), 32'd0);

        foreach (vecs[i]) begin
            sweep(vecs[i].fm, vecs[i].ex, vecs[i].mid_start, de, te);
            check($sformatf("v%0d_done_edge", i), 32'(de), 32'd25);
            check($sformatf("v%0d_xyz_busy_track", i), 32'(te), 32'd0);
            check($sformatf("v%0d_table", i), 32'(tbl), 32'(vecs[i].exp_table));
            check($sformatf("v%0d_match", i), 32'(match), 32'(cfg_match(vecs[i].exp_match)));
            check($sformatf("v%0d_mismatch_row", i), 32'(mismatch_row),
                  32'(cfg_row(vecs[i].exp_row)));
        end

        // start held high: second sweep accepted the cycle after done
        fmask       = 8'hA5;
        expected    = 8'h00;
        first_done  = 0;
        second_done = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 26) check("hold_first_table", 32'(tbl), 32'hA5);
            if (k == 27) begin
                check("hold_restart_cleared", 32'({tbl, match, mismatch_row, xyz}), 32'd0);
                check("hold_restart_busy", 32'(busy), 32'd1);
                start = 1'b0;
            end
            if (done === 1'b1) begin
                if (first_done == 0) first_done = k;
                else if (second_done == 0) second_done = k;
            end
        end
        check("hold_first_done", 32'(first_done), 32'd25);
        check("hold_second_done", 32'(second_done), 32'd51);
        check("hold_second_table", 32'(tbl), 32'hA5);

        // asynchronous reset mid-sweep
        fmask    = 8'hFF;
        expected = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_reset_table", 32'(tbl), 32'h03);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs",
                 32'({xyz, busy, done, tbl, match, mismatch_row}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("no_done_after_reset", 32'(bad), 32'd0);
        sweep(8'h54, 8'h54, 1'b0, de, te);
        check("post_reset_done_edge", 32'(de), 32'd25);
        check("post_reset_track", 32'(te), 32'd0);
        check("post_reset_table", 32'(tbl), 32'h54);
        check("post_reset_match", 32'(match), 32'(cfg_match(1'b1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fxyz_sweep.md
# fxyz_sweep

Sequential stimulus-and-capture stage wrapped around the three-input `fxyz` function block. It drives `x,y,z` through every input row in ascending order and holds each row long enough for the downstream combinational logic to settle. It samples the function output once per row and assembles the captured truth table as a minterm mask. Optionally, it compares that mask against an expected mask and reports the first failing row.

## Interface
- `N`, 3: number of function inputs; rows = 2^N; `xyz[N-1]` is `x` (MSB).
- `SETTLE`, 2: cycles each row is held before sampling; legal range ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `s_in` in 1: function output from the `fxyz` instance.
- `expected` in 2^N: golden minterm mask; must be stable on the edge that enters DONE.
- `xyz` out N: row index driven to the function inputs.
- `busy` out 1: high while sweeping (SETTLE, SAMPLE).
- `done` out 1: one-cycle pulse at sweep end.
- `table` out 2^N: captured mask; bit i = `s_in` at row i.
- `match` out 1: captured mask equals `expected`.
- `mismatch_row` out N: lowest differing row index; 0 when matching.

## Operation
- Reset values: state IDLE, `xyz`=0, `busy`=0, `done`=0, `table`=0, `match`=0, `mismatch_row`=0, row counter 0, settle counter 0.
- IDLE: on `start`=1 the block clears `table`, `match` and `mismatch_row`, and sets row=0, `xyz`=0 and cnt=SETTLE-1. It then moves to SETTLE.
- SETTLE: if cnt=0, go to SAMPLE; otherwise decrement cnt.
- SAMPLE: write `table[row]` <= `s_in`.
  - Last row (2^N-1): go to DONE.
  - Otherwise: row++, `xyz`=row+1, cnt=SETTLE-1, return to SETTLE.
- DONE:
  - `done`=1 and `busy`=0 for one cycle, then return to IDLE.
  - `match` and `mismatch_row` are registered on the edge entering DONE, computed from the final table including the last sampled bit.
  - Both hold until the next accepted `start`.
- `xyz` holds the last row (2^N-1) after the sweep until the next `start`.
- `start` is ignored in SETTLE, SAMPLE and DONE. If `start` is held high, a new sweep is accepted in the IDLE cycle that follows DONE.
- Reset mid-sweep aborts immediately: all outputs return to their reset values and no `done` pulse is issued.
- The settle counter is `$clog2(SETTLE+1)` bits wide and the row counter is N bits. The last-row compare is explicit, not overflow-based.

## Timing
- Counting the edge that samples `start` as edge 1:
  - Row r is driven on `xyz` from edge 1+r·(SETTLE+1).
  - Row r is sampled on edge (r+1)·(SETTLE+1)+1.
  - `done` rises at edge 1+2^N·(SETTLE+1). With defaults this is edge 25.
- Each `xyz` value is stable for exactly SETTLE+1 cycles.
- `s_in` is sampled on the same edge that updates `xyz` to the next row.
- `busy` rises at edge 1 and falls on the edge entering DONE.

## Configuration
- `FXYZ_SWEEP_CHECK_EN` defined:
  - `expected` compare logic and first-difference encoder are compiled in.
  - `match` and `mismatch_row` behave as specified above.
- Undefined:
  - No compare logic is present and `expected` is unused.
  - `match` and `mismatch_row` are tied to 0.
  - Sweep, `table`, `busy` and `done` timing are unchanged.

## Structure
- Package `fxyz_pkg` holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - the default N and SETTLE;
  - the ROWS = 2^N localparam;
  - the golden `fxyz` mask constant 8'h54, for benches.
- Sub-module `fxyz_first_diff`: combinational priority encoder over (table ^ expected) returning the lowest set index. It is instantiated only under `FXYZ_SWEEP_CHECK_EN`.

## Test plan
- Golden sweep:
  - Stimulus: `s_in` wired to an `fxyz` instance, `expected`=8'h54, pulse `start`.
  - Required: `done` at edge 25, `table`=8'h54, `match`=1, `mismatch_row`=0.
- Mismatch:
  - Stimulus: same wiring, `expected`=8'h56.
  - Required: `table`=8'h54, `match`=0, `mismatch_row`=1.
- Row timing:
  - Check `xyz` steps 0→7, each value held 3 cycles.
  - `busy` high at edges 1–24.
  - After `done`, `xyz` stays at 7.
- Start handling:
  - A `start` pulse during the sweep is ignored; `done` still occurs at edge 25.
  - `start` held high gives a second sweep accepted the cycle after DONE, with `table` cleared at that point.
- Reset mid-sweep:
  - Stimulus: assert `reset` at edge 10, asynchronously.
  - Required: outputs are 0 immediately; no `done` pulse follows.
  - Required: a subsequent `start` produces a full correct sweep.
- Without `FXYZ_SWEEP_CHECK_EN`:
  - Stimulus: golden sweep with `expected`=8'hFF.
  - Required: `table`=8'h54, `match`=0, `mismatch_row`=0, `done` at edge 25.
